// File: rtl/ipf_pkg.sv
// Shared constants, state encoding and the divide-by-9 helper for the 3x3 box-mean engine.
package ipf_pkg;

  localparam int IMG_W      = 128;
  localparam int IMG_H      = 128;
  localparam int AW         = 14;
  localparam int DW         = 8;
  localparam int ACC_W      = 12;
  localparam int DIV9_MUL   = 7282;
  localparam int DIV9_SHIFT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } ipf_state_e;

  // Multiply-shift reciprocal; exact floor(acc/9) for every acc up to 9*255.
  function automatic logic [DW-1:0] div9(input logic [ACC_W-1:0] acc);
    logic [ACC_W+12:0] prod;
    prod = (ACC_W+13)'(acc) * (ACC_W+13)'(DIV9_MUL);
    return prod[DIV9_SHIFT +: DW];
  endfunction

endpackage

// File: rtl/ipf_tap_gen.sv
// Maps (row, col, tap k) to the neighbour address and flags taps that fall outside the image.
module ipf_tap_gen
  import ipf_pkg::*;
#(
  parameter int W_LOG2 = 7,
  parameter int H_LOG2 = 7
) (
  input  logic [H_LOG2-1:0]        row_i,
  input  logic [W_LOG2-1:0]        col_i,
  input  logic [3:0]               k_i,
  output logic                     in_bounds_o,
  output logic [W_LOG2+H_LOG2-1:0] addr_o
);

  logic [1:0]      dr;
  logic [1:0]      dc;
  logic [H_LOG2:0] nr;
  logic [W_LOG2:0] nc;

  // One guard bit on each coordinate: -1 and DIM both land with the guard bit set.
  always_comb begin
    dr = 2'd2;
    case (k_i)
      4'd0, 4'd1, 4'd2: dr = 2'd0;
      4'd3, 4'd4, 4'd5: dr = 2'd1;
      default:          dr = 2'd2;
    endcase
    dc          = 2'(k_i % 4'd3);
    nr          = (H_LOG2+1)'({1'b0, row_i}) + (H_LOG2+1)'(dr) - (H_LOG2+1)'(1);
    nc          = (W_LOG2+1)'({1'b0, col_i}) + (W_LOG2+1)'(dc) - (W_LOG2+1)'(1);
    in_bounds_o = ~nr[H_LOG2] & ~nc[W_LOG2];
    addr_o      = {nr[H_LOG2-1:0], nc[W_LOG2-1:0]};
  end

endmodule

// File: rtl/ipf_box3x3_engine.sv
// Raster-order 3x3 zero-padded mean: 9 tap reads, one drain cycle, one result write per pixel.
module ipf_box3x3_engine
  import ipf_pkg::*;
#(
  parameter  int W_LOG2 = 7,
  parameter  int H_LOG2 = 7,
  localparam int AW     = W_LOG2 + H_LOG2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  output logic          ipf_valid,
  output logic [AW-1:0] ipf_addr,
  output logic [DW-1:0] ipf_data,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state_o
);

  // Interfaces: gray_req is a request with fixed 1-cycle read latency (no ready);
  // ipf_valid is a write strobe with no back-pressure, sampled downstream on the falling edge.

  ipf_state_e       state_q, state_d;
  logic [AW-1:0]    pix_q, pix_d;
  logic [3:0]       k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             req_d1_q;

  logic             gray_req_q, gray_req_d;
  logic [AW-1:0]    gray_addr_q, gray_addr_d;
  logic             ipf_valid_q, ipf_valid_d;
  logic [AW-1:0]    ipf_addr_q, ipf_addr_d;
  logic [DW-1:0]    ipf_data_q, ipf_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tap_in_bounds;
  logic [AW-1:0]    tap_addr;

  // Taps are generated for the next cycle's (pixel, k) so the registered request lines up with FETCH.
  ipf_tap_gen #(
    .W_LOG2(W_LOG2),
    .H_LOG2(H_LOG2)
  ) u_tap_gen (
    .row_i      (pix_d[AW-1:W_LOG2]),
    .col_i      (pix_d[W_LOG2-1:0]),
    .k_i        (k_d),
    .in_bounds_o(tap_in_bounds),
    .addr_o     (tap_addr)
  );

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    k_d     = k_q;
    acc_d   = req_d1_q ? acc_q + ACC_W'(gray_data) : acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pix_d   = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      FETCH: begin
        if (k_q == 4'd8) state_d = DRAIN;
        else             k_d     = k_q + 4'd1;
      end
      DRAIN: state_d = WRITE;
      WRITE: begin
        acc_d = '0;
        k_d   = '0;
        if (pix_q == '1) begin
          state_d = DONE;
        end else begin
          pix_d   = pix_q + AW'(1);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output registers load from next-state values so each strobe sits inside its own state.
    gray_req_d  = (state_d == FETCH) && tap_in_bounds;
    gray_addr_d = gray_req_d ? tap_addr : '0;
    ipf_valid_d = (state_d == WRITE);
    ipf_addr_d  = ipf_valid_d ? pix_d : '0;
    ipf_data_d  = ipf_valid_d ? div9(acc_d) : '0;
    busy_d      = (state_d == FETCH) || (state_d == DRAIN) || (state_d == WRITE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      req_d1_q    <= 1'b0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      ipf_valid_q <= 1'b0;
      ipf_addr_q  <= '0;
      ipf_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      req_d1_q    <= gray_req_q;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      ipf_valid_q <= ipf_valid_d;
      ipf_addr_q  <= ipf_addr_d;
      ipf_data_q  <= ipf_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign gray_req    = gray_req_q;
  assign gray_addr   = gray_addr_q;
  assign ipf_valid   = ipf_valid_q;
  assign ipf_addr    = ipf_addr_q;
  assign ipf_data    = ipf_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ipf_box3x3_engine.sv
// Scoreboard bench for the box-mean engine on a reduced 16x8 image, with a behavioural mean model.
module tb_ipf_box3x3_engine;

  localparam int WL   = 4;
  localparam int HL   = 3;
  localparam int IW   = 1 << WL;
  localparam int IH   = 1 << HL;
  localparam int NPIX = IW * IH;
  localparam int AW   = WL + HL;
  localparam int DW   = 8;
  localparam int PASS_CYC = 11 * NPIX;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          ipf_valid;
  logic [AW-1:0] ipf_addr;
  logic [DW-1:0] ipf_data;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  logic [DW-1:0]    img [NPIX];
  logic [AW+DW-1:0] exp_q[$];

  int n_cmp;
  int n_err;
  int pop_cnt;
  int rd_cnt;
  int done_cnt;
  int cyc;

  ipf_box3x3_engine #(.W_LOG2(WL), .H_LOG2(HL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .ipf_valid  (ipf_valid),
    .ipf_addr   (ipf_addr),
    .ipf_data   (ipf_data),
    .busy       (busy),
    .done       (done),
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Input memory: 1-cycle latency; garbage when not requested so qualification matters.
  always @(posedge clk) gray_data <= gray_req ? img[gray_addr] : DW'($urandom);

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 3x3 zero-padded neighbourhood sum divided by 9.
  function automatic int ref_pix(input int r, input int c);
    int sum;
    sum = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < IH && c + dc >= 0 && c + dc < IW)
          sum += int'(img[(r + dr) * IW + (c + dc)]);
    return sum / 9;
  endfunction

  function automatic int ref_reads();
    int n;
    n = 0;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < IH && c + dc >= 0 && c + dc < IW) n++;
    return n;
  endfunction

  task automatic fill_image(input int mode);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        case (mode)
          0:       img[r * IW + c] = 8'd100;
          1:       img[r * IW + c] = 8'd255;
          2:       img[r * IW + c] = (r == 5 && c == 5) ? 8'd255 : 8'd0;
          3:       img[r * IW + c] = DW'((r + c) & 255);
          default: img[r * IW + c] = DW'($urandom_range(0, 255));
        endcase
  endtask

  // monitor: pops and compares every result write at the falling edge
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst_n) begin
      if (ipf_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_write: addr %0d data %0d with empty queue", ipf_addr, ipf_data);
        end else begin
          e = exp_q.pop_front();
          check("ipf_addr", int'(ipf_addr), int'(e[AW+DW-1:DW]));
          check("ipf_data", int'(ipf_data), int'(e[DW-1:0]));
          pop_cnt++;
        end
      end
      if (gray_req) rd_cnt++;
      if (done) done_cnt++;
    end
  end

  // driver: one pass; restart_at re-pulses start mid-pass, reset_at aborts with rst_n
  task automatic run_pass(input int restart_at, input int reset_at);
    int  c0;
    bit  seen;
    bit  fired;
    exp_q.delete();
    pop_cnt  = 0;
    rd_cnt   = 0;
    done_cnt = 0;
    for (int p = 0; p < NPIX; p++) exp_q.push_back({AW'(p), DW'(ref_pix(p / IW, p % IW))});
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c0    = cyc;
    seen  = 1'b0;
    fired = 1'b0;
    for (int i = 0; i < PASS_CYC + 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_after_start", int'(busy), 1);
      if (done) begin
        seen = 1'b1;
        check("done_latency", cyc - c0, PASS_CYC);
      end else if (restart_at >= 0 && !fired && pop_cnt >= restart_at) begin
        fired = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else if (reset_at >= 0 && pop_cnt >= reset_at) begin
        rst_n = 1'b0;
        #1;
        check("outputs_in_reset",
              int'({gray_req, gray_addr, ipf_valid, ipf_addr, ipf_data, busy, done, dbg_state}), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", PASS_CYC + 20);
    end
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("done_count", done_cnt, 1);
    check("writes_count", pop_cnt, NPIX);
    check("queue_left", exp_q.size(), 0);
    check("in_bounds_reads", rd_cnt, ref_reads());
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    fill_image(0);
    #1;
    check("reset_outputs",
          int'({gray_req, gray_addr, ipf_valid, ipf_addr, ipf_data, busy, done, dbg_state}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    fill_image(0); run_pass(-1, -1);
    fill_image(1); run_pass(-1, -1);
    fill_image(2); run_pass(-1, -1);
    fill_image(3); run_pass(-1, -1);
    fill_image(4); run_pass(50, -1);
    fill_image(4); run_pass(-1, 20);
    run_pass(-1, -1);
    fill_image(4); run_pass(-1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
